// File: rtl/req_chan_arb_pkg.sv
// Shared types and constants for the request-channel arbiter.
// State encoding 2'b11 is never entered and is treated as idle by the FSM.
package req_chan_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GRANT = 2'b01,
    ARB_BUSY  = 2'b10
  } arb_state_e;

  localparam int MGR_IDW = 2;
  localparam int ATOP_W  = 6;

  function automatic logic [MGR_IDW-1:0] next_ptr(input logic [MGR_IDW-1:0] win,
                                                  input int nreq);
    int nxt;
    logic [MGR_IDW-1:0] res;
    nxt = (int'(win) + 1) % nreq;
    res = nxt[MGR_IDW-1:0];
    return res;
  endfunction

endpackage

// File: rtl/req_chan_arb_rr_picker.sv
// Combinational round-robin picker: lowest upward distance from ptr wins.
// Distance arithmetic avoids variable-width indexing of the request vector.
module req_rr_picker
  import req_chan_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]    req,
  input  logic [MGR_IDW-1:0] ptr,
  output logic               any,
  output logic [MGR_IDW-1:0] win
);

  always_comb begin
    int best_d;
    int d;
    any    = 1'b0;
    win    = '0;
    best_d = NREQ;
    d      = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + NREQ - int'(ptr)) % NREQ;
      if (req[i] && (d < best_d)) begin
        best_d = d;
        any    = 1'b1;
        win    = i[MGR_IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/req_chan_arb.sv
// Round-robin arbiter sharing one A channel between NREQ request managers.
// Grant is a registered one-cycle pulse; ownership lasts until the handshake.
module req_chan_arb
  import req_chan_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 4,
  parameter int AW   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_rq,
  output logic [NREQ-1:0]          gnt_rq,
  input  logic [NREQ-1:0]          m_a_valid,
  output logic [NREQ-1:0]          m_a_ready,
  input  logic [NREQ*IDW-1:0]      m_a_id,
  input  logic [NREQ*AW-1:0]       m_a_addr,
  input  logic [NREQ*ATOP_W-1:0]   m_a_atop,
  output logic                     s_a_valid,
  input  logic                     s_a_ready,
  output logic [IDW-1:0]           s_a_id,
  output logic [AW-1:0]            s_a_addr,
  output logic [ATOP_W-1:0]        s_a_atop,
  output logic [MGR_IDW-1:0]       owner,
  output logic                     busy,
  output logic                     prot_err
);

  arb_state_e         state_q, state_d;
  logic [MGR_IDW-1:0] owner_q, owner_d;
  logic [MGR_IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic               prot_err_q, prot_err_d;

  logic               pick_any;
  logic [MGR_IDW-1:0] pick_win;
  logic [NREQ-1:0]    owner_oh;
  logic               handshake;
  logic               err;

  req_rr_picker #(.NREQ(NREQ)) u_picker (
    .req (req_rq),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .win (pick_win)
  );

  always_comb begin
    owner_oh = '0;
    for (int i = 0; i < NREQ; i++) owner_oh[i] = (owner_q == i[MGR_IDW-1:0]);
  end

  // Only the owner is connected, and only while BUSY.
  always_comb begin
    s_a_valid = 1'b0;
    s_a_id    = '0;
    s_a_addr  = '0;
    s_a_atop  = '0;
    m_a_ready = '0;
    if (state_q == ARB_BUSY) begin
      for (int i = 0; i < NREQ; i++) begin
        if (owner_oh[i]) begin
          s_a_valid    = m_a_valid[i];
          s_a_id       = m_a_id[i*IDW +: IDW];
          s_a_addr     = m_a_addr[i*AW +: AW];
          s_a_atop     = m_a_atop[i*ATOP_W +: ATOP_W];
          m_a_ready[i] = s_a_ready;
        end
      end
    end
  end

  assign handshake = s_a_valid & s_a_ready;

  always_comb begin
    if (state_q == ARB_BUSY) err = (|(m_a_valid & ~owner_oh)) | (|(req_rq & owner_oh));
    else                     err = |m_a_valid;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_d      = '0;
    prot_err_d = prot_err_q | err;
    case (state_q)
      ARB_GRANT: state_d = ARB_BUSY;
      ARB_BUSY: begin
        if (handshake) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
    // A new winner is taken from IDLE, or straight after a handshake.
    if ((state_q != ARB_GRANT) && (state_q != ARB_BUSY || handshake) && pick_any) begin
      state_d  = ARB_GRANT;
      owner_d  = pick_win;
      rr_ptr_d = next_ptr(pick_win, NREQ);
      for (int i = 0; i < NREQ; i++) gnt_d[i] = (pick_win == i[MGR_IDW-1:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      gnt_q      <= '0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_q      <= gnt_d;
      prot_err_q <= prot_err_d;
    end
  end

  assign gnt_rq   = gnt_q;
  assign owner    = owner_q;
  assign busy     = (state_q == ARB_GRANT) || (state_q == ARB_BUSY);
  assign prot_err = prot_err_q;

endmodule
